// File: rtl/nes_pad_reader.sv
// NES controller poller: latches the pad, shifts out eight buttons and presents them as registered levels.
// Optional macro NES_PRESENCE_EN adds a 9th sample used to detect a connected controller (io_present).
module nes_pad_reader #(
    parameter int unsigned LATCH_CYCLES = 900,
    parameter int unsigned HALF_CYCLES  = 450,
    parameter int unsigned POLL_CYCLES  = 1237500
) (
    input  logic clock,
    input  logic reset,
    input  logic io_padData,
    output logic io_padLatch,
    output logic io_padClock,
    output logic io_a,
    output logic io_b,
    output logic io_select,
    output logic io_start,
    output logic io_up,
    output logic io_down,
    output logic io_left,
    output logic io_right,
`ifdef NES_PRESENCE_EN
    output logic io_present,
`endif
    output logic io_valid
);

    localparam int unsigned PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int unsigned POLL_W    = $clog2(POLL_CYCLES);
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned BTN_W     = 8;

    localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_CYCLES - 1);
    localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(7);
`ifdef NES_PRESENCE_EN
    localparam logic [IDX_W-1:0]   IDX_NINTH  = IDX_W'(8);
`endif

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        UPDATE
    } state_t;

    state_t             state, state_d;
    logic [POLL_W-1:0]  poll, poll_d;
    logic [PHASE_W-1:0] phase, phase_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [BTN_W-1:0]   shift, shift_d;
    logic [BTN_W-1:0]   btn, btn_d;
    logic               latch_d, pclk_d, valid_d;
    logic               sync1, sync2;
`ifdef NES_PRESENCE_EN
    logic               present, present_d;
    logic               sample9;
`endif

    // Two-flop synchroniser for the asynchronous pad data line
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= io_padData;
            sync2 <= sync1;
        end
    end

    // State, counters and all outputs are registered together
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            poll        <= '0;
            phase       <= '0;
            idx         <= '0;
            shift       <= '0;
            btn         <= '0;
            io_padLatch <= 1'b0;
            io_padClock <= 1'b0;
            io_valid    <= 1'b0;
`ifdef NES_PRESENCE_EN
            present     <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            poll        <= poll_d;
            phase       <= phase_d;
            idx         <= idx_d;
            shift       <= shift_d;
            btn         <= btn_d;
            io_padLatch <= latch_d;
            io_padClock <= pclk_d;
            io_valid    <= valid_d;
`ifdef NES_PRESENCE_EN
            present     <= present_d;
`endif
        end
    end

    // Next-state, counters, shift capture and output next values
    always_comb begin
        state_d = state;
        poll_d  = poll + POLL_W'(1);
        phase_d = phase + PHASE_W'(1);
        idx_d   = idx;
        shift_d = shift;
        btn_d   = btn;
`ifdef NES_PRESENCE_EN
        present_d = present;
        sample9   = 1'b1;
`endif

        case (state)
            IDLE: begin
                if (poll == POLL_LAST) state_d = LATCH;
            end
            LATCH: begin
                if (phase == LATCH_LAST) begin
                    state_d = LOW;
                    idx_d   = '0;
                end
            end
            LOW: begin
                if (phase == HALF_LAST) begin
`ifdef NES_PRESENCE_EN
                    if (idx == IDX_NINTH) begin
                        // 9th bit is taken uninverted: 0 means a real pad drove the line
                        sample9 = sync2;
                        state_d = UPDATE;
                    end else begin
                        shift_d[idx[2:0]] = ~sync2;
                        state_d           = HIGH;
                    end
`else
                    shift_d[idx[2:0]] = ~sync2;
                    state_d           = HIGH;
`endif
                end
            end
            HIGH: begin
                if (phase == HALF_LAST) begin
                    idx_d = idx + IDX_W'(1);
`ifdef NES_PRESENCE_EN
                    state_d = LOW;
`else
                    state_d = (idx == IDX_LAST) ? UPDATE : LOW;
`endif
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state) phase_d = '0;
        if (state_d == LATCH && state != LATCH) poll_d = '0;

        // Buttons load on the edge that enters UPDATE, together with valid
        if (state_d == UPDATE && state != UPDATE) begin
`ifdef NES_PRESENCE_EN
            btn_d     = sample9 ? '0 : shift_d;
            present_d = ~sample9;
`else
            btn_d     = shift_d;
`endif
        end

        latch_d = (state_d == LATCH);
        pclk_d  = (state_d == HIGH);
        valid_d = (state_d == UPDATE);
    end

    assign io_a      = btn[0];
    assign io_b      = btn[1];
    assign io_select = btn[2];
    assign io_start  = btn[3];
    assign io_up     = btn[4];
    assign io_down   = btn[5];
    assign io_left   = btn[6];
    assign io_right  = btn[7];
`ifdef NES_PRESENCE_EN
    assign io_present = present;
`endif

endmodule
